// File: rtl/vadd_stream_ctrl_if.sv
// Signal bundle around the 4-lane vector-add stream controller.
// It covers the upstream operand handshake, the add-stage operand/CE/result
// lanes, and the downstream result handshake with the FIFO occupancy.
interface vadd_stream_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a_0, in_a_1, in_a_2, in_a_3;
    logic [WIDTH-1:0] in_b_0, in_b_1, in_b_2, in_b_3;
    logic [WIDTH-1:0] add_a_0, add_a_1, add_a_2, add_a_3;
    logic [WIDTH-1:0] add_b_0, add_b_1, add_b_2, add_b_3;
    logic             add_en;
    logic [WIDTH-1:0] add_y_0, add_y_1, add_y_2, add_y_3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y_0, out_y_1, out_y_2, out_y_3;
    logic [CW-1:0]    count;

    // Controller side.
    modport master (
        input  in_valid, in_a_0, in_a_1, in_a_2, in_a_3,
               in_b_0, in_b_1, in_b_2, in_b_3,
               add_y_0, add_y_1, add_y_2, add_y_3, out_ready,
        output in_ready, add_a_0, add_a_1, add_a_2, add_a_3,
               add_b_0, add_b_1, add_b_2, add_b_3, add_en,
               out_valid, out_y_0, out_y_1, out_y_2, out_y_3, count
    );

    // Producer / add stage / consumer side.
    modport slave (
        output in_valid, in_a_0, in_a_1, in_a_2, in_a_3,
               in_b_0, in_b_1, in_b_2, in_b_3,
               add_y_0, add_y_1, add_y_2, add_y_3, out_ready,
        input  in_ready, add_a_0, add_a_1, add_a_2, add_a_3,
               add_b_0, add_b_1, add_b_2, add_b_3, add_en,
               out_valid, out_y_0, out_y_1, out_y_2, out_y_3, count
    );
endinterface

// File: rtl/vadd_stream_ctrl.sv
// Valid/ready wrapper around a LAT-deep 4-lane vector-add stage.
// vld[k] marks add-stage rank k as holding a real vector. The add stage is
// frozen through its CE (add_en) only when a real result sits in P and the
// result FIFO cannot take it this cycle. Results are buffered in a small
// circular FIFO so that the consumer can stall without losing data.
module vadd_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    vadd_stream_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = 4 * WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [LAT:1]  vld;
    logic [VW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_next;
    logic          head_valid;
    logic          full;
    logic          pop;
    logic          room;
    logic          add_en;
    logic          push;
    logic [VW-1:0] p_vec;
    logic [VW-1:0] head;

    // Operands pass straight through to the add stage; the controller never touches data.
    assign bus.add_a_0 = bus.in_a_0;
    assign bus.add_a_1 = bus.in_a_1;
    assign bus.add_a_2 = bus.in_a_2;
    assign bus.add_a_3 = bus.in_a_3;
    assign bus.add_b_0 = bus.in_b_0;
    assign bus.add_b_1 = bus.in_b_1;
    assign bus.add_b_2 = bus.in_b_2;
    assign bus.add_b_3 = bus.in_b_3;

    assign p_vec = {bus.add_y_3, bus.add_y_2, bus.add_y_1, bus.add_y_0};
    assign head  = mem[rd_ptr];

    assign bus.add_en    = add_en;
    assign bus.in_ready  = add_en;
    assign bus.out_valid = head_valid;
    assign bus.count     = occ;
    assign bus.out_y_0   = head[0*WIDTH +: WIDTH];
    assign bus.out_y_1   = head[1*WIDTH +: WIDTH];
    assign bus.out_y_2   = head[2*WIDTH +: WIDTH];
    assign bus.out_y_3   = head[3*WIDTH +: WIDTH];

    // Handshake decode: pipeline advances unless a real P value has nowhere to go.
    // out_ready reaches add_en/in_ready combinationally so a full FIFO keeps streaming.
    always_comb begin
        full   = (occ == FULL_COUNT);
        pop    = head_valid && bus.out_ready;
        room   = !full || pop;
        add_en = !vld[LAT] || room;
        push   = add_en && vld[LAT];
        case ({push, pop})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    // Slot tracking: shift the real-data markers on every CE edge, bubbles included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= {LAT{1'b0}};
        end else if (add_en) begin
            for (int k = LAT; k >= 2; k--) begin
                vld[k] <= vld[k-1];
            end
            vld[1] <= bus.in_valid;
        end
    end

    // Result FIFO storage and write pointer: capture P whenever a real vector leaves the stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {VW{1'b0}};
            end
            wr_ptr <= {AW{1'b0}};
        end else if (push) begin
            mem[wr_ptr] <= p_vec;
            wr_ptr      <= wr_ptr + AW'(1);
        end
    end

    // Read pointer, occupancy and registered not-empty flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= {AW{1'b0}};
            occ        <= {CW{1'b0}};
            head_valid <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ        <= occ_next;
            head_valid <= (occ_next != {CW{1'b0}});
        end
    end
endmodule

// File: tb/tb_vadd_stream_ctrl.sv
// Directed bench for vadd_stream_ctrl with a behavioural 2-rank add stage
// (input registers plus P register, both gated by add_en).
module tb_vadd_stream_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] got[$];

    vadd_stream_ctrl_if #(.WIDTH(8), .DEPTH(4)) bus ();

    vadd_stream_ctrl #(.WIDTH(8), .LAT(2), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Behavioural add stage: rank 1 = operand registers, rank 2 = P (lane sums mod 256).
    logic [7:0] ra[4], rb[4], p[4];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin ra[k] <= 8'd0; rb[k] <= 8'd0; p[k] <= 8'd0; end
        end else if (bus.add_en) begin
            ra[0] <= bus.add_a_0; ra[1] <= bus.add_a_1; ra[2] <= bus.add_a_2; ra[3] <= bus.add_a_3;
            rb[0] <= bus.add_b_0; rb[1] <= bus.add_b_1; rb[2] <= bus.add_b_2; rb[3] <= bus.add_b_3;
            for (int k = 0; k < 4; k++) p[k] <= ra[k] + rb[k];
        end
    end
    assign bus.add_y_0 = p[0];
    assign bus.add_y_1 = p[1];
    assign bus.add_y_2 = p[2];
    assign bus.add_y_3 = p[3];

    logic [31:0] out_vec, add_a_vec, add_b_vec;
    assign out_vec   = {bus.out_y_3, bus.out_y_2, bus.out_y_1, bus.out_y_0};
    assign add_a_vec = {bus.add_a_3, bus.add_a_2, bus.add_a_1, bus.add_a_0};
    assign add_b_vec = {bus.add_b_3, bus.add_b_2, bus.add_b_1, bus.add_b_0};

    // Consumer monitor: record every head entry that will be popped at the coming edge.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) got.push_back(out_vec);
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_vec(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        {bus.in_a_3, bus.in_a_2, bus.in_a_1, bus.in_a_0} = a;
        {bus.in_b_3, bus.in_b_2, bus.in_b_1, bus.in_b_0} = b;
    endtask

    // Offer vectors a=b={4{base+i}} until n are accepted or the budget runs out.
    task automatic feed(input int n, input int base, input int budget);
        int acc = 0;
        int cyc = 0;
        logic [7:0] v;
        while (acc < n && cyc < budget) begin
            v = 8'(base + acc);
            set_vec(1'b1, {4{v}}, {4{v}});
            #1;
            if (bus.in_ready) acc++;
            tick();
            cyc++;
        end
        set_vec(1'b0, 32'h0, 32'h0);
        checks++; if (acc !== n) begin failures++; $display("FAIL feed_accepted got=%0d exp=%0d", acc, n); end
    endtask

    task automatic test_reset;
        set_vec(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        checks++; if (out_vec !== 32'h0) begin failures++; $display("FAIL rst_out_y got=%h exp=00000000", out_vec); end
        reset = 1'b0;
        tick();
        checks++; if (bus.add_en !== 1'b1) begin failures++; $display("FAIL rst_add_en got=%b exp=1", bus.add_en); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rel_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_single;
        got.delete();
        bus.out_ready = 1'b1;
        set_vec(1'b1, 32'h04030201, 32'h281E140A);
        #1;
        checks++; if (add_a_vec !== 32'h04030201) begin failures++; $display("FAIL single_add_a got=%h exp=04030201", add_a_vec); end
        checks++; if (add_b_vec !== 32'h281E140A) begin failures++; $display("FAIL single_add_b got=%h exp=281e140a", add_b_vec); end
        tick();
        set_vec(1'b1, 32'h0, 32'h0);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", bus.out_valid); end
        set_vec(1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (out_vec !== 32'h2C21160B) begin failures++; $display("FAIL single_out_y got=%h exp=2c21160b", out_vec); end
        checks++; if (bus.count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        repeat (4) tick();
        checks++; if (got.size() !== 2) begin failures++; $display("FAIL single_n_results got=%0d exp=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 32'h2C21160B) begin failures++; $display("FAIL single_res0 got=%h exp=2c21160b", got[0]); end
            checks++; if (got[1] !== 32'h0) begin failures++; $display("FAIL single_res1 got=%h exp=00000000", got[1]); end
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL single_final_count got=%0d exp=0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_final_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_lane_wrap;
        got.delete();
        bus.out_ready = 1'b1;
        set_vec(1'b1, 32'h00C880FF, 32'h00648001);
        tick();
        set_vec(1'b0, 32'h00C880FF, 32'h00648001);
        repeat (5) tick();
        set_vec(1'b0, 32'h0, 32'h0);
        checks++; if (got.size() !== 1) begin failures++; $display("FAIL wrap_n_results got=%0d exp=1", got.size()); end
        if (got.size() == 1) begin
            checks++; if (got[0] !== 32'h002C0000) begin failures++; $display("FAIL wrap_value got=%h exp=002c0000", got[0]); end
        end
    endtask

    task automatic test_back_pressure;
        logic [7:0] s;
        got.delete();
        bus.out_ready = 1'b0;
        feed(6, 0, 40);
        set_vec(1'b1, {4{8'd6}}, {4{8'd6}});
        #1;
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", bus.count); end
        checks++; if (bus.add_en !== 1'b0) begin failures++; $display("FAIL bp_add_en got=%b exp=0", bus.add_en); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (out_vec !== 32'h0) begin failures++; $display("FAIL bp_head got=%h exp=00000000", out_vec); end
        tick();
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL bp_hold_count got=%0d exp=4", bus.count); end
        checks++; if (bus.add_en !== 1'b0) begin failures++; $display("FAIL bp_hold_add_en got=%b exp=0", bus.add_en); end
        bus.out_ready = 1'b1;
        feed(2, 6, 40);
        repeat (12) tick();
        checks++; if (got.size() !== 8) begin failures++; $display("FAIL bp_n_results got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            s = 8'(2 * i);
            checks++; if (got[i] !== {4{s}}) begin failures++; $display("FAIL bp_res%0d got=%h exp=%h", i, got[i], {4{s}}); end
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL bp_final_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full_pop;
        logic [7:0] v;
        logic [7:0] s;
        got.delete();
        bus.out_ready = 1'b0;
        feed(6, 10, 40);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            v = 8'(16 + c);
            set_vec(1'b1, {4{v}}, {4{v}});
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready%0d got=%b exp=1", c, bus.in_ready); end
            checks++; if (bus.count !== 3'd4) begin failures++; $display("FAIL full_hold%0d got=%0d exp=4", c, bus.count); end
            tick();
        end
        checks++; if (got.size() !== 5) begin failures++; $display("FAIL full_rate got=%0d exp=5", got.size()); end
        set_vec(1'b0, 32'h0, 32'h0);
        repeat (12) tick();
        checks++; if (got.size() !== 11) begin failures++; $display("FAIL full_n_results got=%0d exp=11", got.size()); end
        for (int i = 0; i < 11 && i < got.size(); i++) begin
            s = 8'(2 * (10 + i));
            checks++; if (got[i] !== {4{s}}) begin failures++; $display("FAIL full_res%0d got=%h exp=%h", i, got[i], {4{s}}); end
        end
    endtask

    task automatic test_bubbles;
        got.delete();
        bus.out_ready = 1'b1;
        set_vec(1'b1, 32'h01020304, 32'h10101010);
        tick();
        set_vec(1'b0, 32'hAAAAAAAA, 32'h55555555);
        tick();
        set_vec(1'b1, 32'h05060708, 32'h20202020);
        tick();
        set_vec(1'b0, 32'hAAAAAAAA, 32'h55555555);
        tick();
        set_vec(1'b0, 32'h0, 32'h0);
        repeat (6) tick();
        checks++; if (got.size() !== 2) begin failures++; $display("FAIL bub_n_results got=%0d exp=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 32'h11121314) begin failures++; $display("FAIL bub_res0 got=%h exp=11121314", got[0]); end
            checks++; if (got[1] !== 32'h25262728) begin failures++; $display("FAIL bub_res1 got=%h exp=25262728", got[1]); end
        end
    endtask

    task automatic test_async_reset;
        got.delete();
        bus.out_ready = 1'b0;
        feed(5, 40, 40);
        checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL ar_pre_count got=%0d exp=3", bus.count); end
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", bus.count); end
        checks++; if (out_vec !== 32'h0) begin failures++; $display("FAIL ar_out_y got=%h exp=00000000", out_vec); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", bus.in_ready); end
        repeat (2) tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        got.delete();
        set_vec(1'b1, 32'h05050505, 32'h01010101);
        tick();
        set_vec(1'b0, 32'h0, 32'h0);
        repeat (6) tick();
        checks++; if (got.size() !== 1) begin failures++; $display("FAIL ar_n_results got=%0d exp=1", got.size()); end
        if (got.size() == 1) begin
            checks++; if (got[0] !== 32'h06060606) begin failures++; $display("FAIL ar_value got=%h exp=06060606", got[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lane_wrap();
        test_back_pressure();
        test_full_pop();
        test_bubbles();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
